// File: rtl/obi_arb_pkg.sv
// Shared types and the round-robin pick helper for the OBI requester arbiter.
package obi_arb_pkg;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_e;

    localparam int unsigned RR_MAX_REQ = 32;
    localparam int unsigned RR_IDX_W   = $clog2(RR_MAX_REQ);

    // First set request bit at or above ptr, wrapping modulo num_req.
    function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                            input int unsigned           ptr,
                                            input int unsigned           num_req);
        int unsigned idx;
        logic        found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
            if (i < num_req && !found) begin
                idx = (ptr + i) % num_req;
                if (req[idx[RR_IDX_W-1:0]]) begin
                    rr_pick = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// In-order FIFO of granted requester indices, used to route responses back.
module obi_id_fifo #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem[wr_ptr_q] <= push_data_i;
                wr_ptr_q      <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/obi_rr_arbiter.sv
// Round-robin arbiter sharing one OBI target port between NUM_REQ requesters,
// with in-order response routing back to the issuing requester.
module obi_rr_arbiter
    import obi_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              s_req_i,
    output logic [NUM_REQ-1:0]              s_gnt_o,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_addr_i,
    input  logic [NUM_REQ-1:0]              s_we_i,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_be_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_wdata_i,
    output logic [NUM_REQ-1:0]              s_rvalid_o,
    output logic [DATA_WIDTH-1:0]           s_rdata_o,
    output logic                            m_req_o,
    input  logic                            m_gnt_i,
    output logic [ADDR_WIDTH-1:0]           m_addr_o,
    output logic                            m_we_o,
    output logic [DATA_WIDTH/8-1:0]         m_be_o,
    output logic [DATA_WIDTH-1:0]           m_wdata_o,
    input  logic                            m_rvalid_i,
    input  logic [DATA_WIDTH-1:0]           m_rdata_i,
    output logic                            err_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned BE_W  = DATA_WIDTH / 8;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] lock_q;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] win_idx;
    logic             have_win;
    logic             handshake;
    logic             pop;
    logic [IDX_W-1:0] fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    assign pick_idx = IDX_W'(rr_pick(RR_MAX_REQ'(s_req_i), 32'(ptr_q), NUM_REQ));

    always_comb begin
        state_d  = state_q;
        have_win = 1'b0;
        win_idx  = pick_idx;
        if (state_q == LOCKED) begin
            have_win = 1'b1;
            win_idx  = lock_q;
        end else begin
            have_win = |s_req_i;
        end

        m_req_o   = have_win & s_req_i[win_idx] & ~fifo_full & ~rst_i;
        handshake = m_req_o & m_gnt_i;

        s_gnt_o = '0;
        if (handshake) begin
            s_gnt_o[win_idx] = 1'b1;
        end

        if (handshake) begin
            state_d = IDLE;
        end else if (have_win) begin
            state_d = LOCKED;
        end

        m_addr_o  = '0;
        m_we_o    = 1'b0;
        m_be_o    = '0;
        m_wdata_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (have_win && win_idx == IDX_W'(k)) begin
                m_addr_o  = s_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
                m_we_o    = s_we_i[k];
                m_be_o    = s_be_i[k*BE_W +: BE_W];
                m_wdata_o = s_wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lock_q  <= '0;
        end else begin
            state_q <= state_d;
            if (have_win && !handshake) begin
                lock_q <= win_idx;
            end
            if (handshake) begin
                ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            end
        end
    end

    // Responses return in grant order, so the FIFO head names the issuer.
    assign pop       = m_rvalid_i & ~fifo_empty & ~rst_i;
    assign s_rdata_o = m_rdata_i;

    always_comb begin
        s_rvalid_o = '0;
        if (pop) begin
            s_rvalid_o[fifo_head] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if (m_rvalid_i && fifo_empty) begin
            err_o <= 1'b1;
        end
    end

    obi_id_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (handshake),
        .push_data_i (win_idx),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_obi_rr_arbiter.sv
// Directed and randomized bench for obi_rr_arbiter against a queue-based reference model.
module tb_obi_rr_arbiter;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 4;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    s_req_i;
    logic [N-1:0]    s_gnt_o;
    logic [N*AW-1:0] s_addr_i;
    logic [N-1:0]    s_we_i;
    logic [N*BW-1:0] s_be_i;
    logic [N*DW-1:0] s_wdata_i;
    logic [N-1:0]    s_rvalid_o;
    logic [DW-1:0]   s_rdata_o;
    logic            m_req_o;
    logic            m_gnt_i;
    logic [AW-1:0]   m_addr_o;
    logic            m_we_o;
    logic [BW-1:0]   m_be_o;
    logic [DW-1:0]   m_wdata_o;
    logic            m_rvalid_i;
    logic [DW-1:0]   m_rdata_i;
    logic            err_o;

    obi_rr_arbiter #(
        .NUM_REQ         (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .s_req_i    (s_req_i),
        .s_gnt_o    (s_gnt_o),
        .s_addr_i   (s_addr_i),
        .s_we_i     (s_we_i),
        .s_be_i     (s_be_i),
        .s_wdata_i  (s_wdata_i),
        .s_rvalid_o (s_rvalid_o),
        .s_rdata_o  (s_rdata_o),
        .m_req_o    (m_req_o),
        .m_gnt_i    (m_gnt_i),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_wdata_o  (m_wdata_o),
        .m_rvalid_i (m_rvalid_i),
        .m_rdata_i  (m_rdata_i),
        .err_o      (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Requester-side view: a set req bit holds its fields until granted.
    logic [N-1:0]  req;
    logic [AW-1:0] f_addr  [N];
    logic          f_we    [N];
    logic [BW-1:0] f_be    [N];
    logic [DW-1:0] f_wdata [N];

    // Reference model state.
    int unsigned checks = 0;
    int unsigned errors = 0;
    int          m_ptr;
    bit          m_locked;
    int          m_lock;
    int          q[$];
    bit          m_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_req_i = req;
        for (int k = 0; k < N; k++) begin
            s_addr_i[k*AW +: AW]  = f_addr[k];
            s_we_i[k]             = f_we[k];
            s_be_i[k*BW +: BW]    = f_be[k];
            s_wdata_i[k*DW +: DW] = f_wdata[k];
        end
    endtask

    task automatic cycle();
        bit           have;
        int           w;
        bit           e_mreq;
        bit           hs;
        bit           e_pop;
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_rv;
        drive();
        #3;
        have = 1'b0;
        w    = 0;
        if (m_locked) begin
            have = 1'b1;
            w    = m_lock;
        end else begin
            for (int i = 0; i < N; i++) begin
                int idx;
                idx = (m_ptr + i) % N;
                if (!have && req[idx[IW-1:0]]) begin
                    have = 1'b1;
                    w    = idx;
                end
            end
        end
        e_mreq = !rst_i && have && req[w[IW-1:0]] && (q.size() < MO);
        hs     = e_mreq && m_gnt_i;
        e_gnt  = hs ? (N'(1) << w) : '0;
        e_pop  = !rst_i && m_rvalid_i && (q.size() != 0);
        e_rv   = e_pop ? (N'(1) << q[0]) : '0;

        chk("m_req_o", 64'(m_req_o), 64'(e_mreq));
        chk("s_gnt_o", 64'(s_gnt_o), 64'(e_gnt));
        chk("s_rvalid_o", 64'(s_rvalid_o), 64'(e_rv));
        chk("s_rdata_o", 64'(s_rdata_o), 64'(m_rdata_i));
        chk("err_o", 64'(err_o), 64'(m_err));
        if (!rst_i) begin
            chk("m_addr_o", 64'(m_addr_o), have ? 64'(f_addr[w[IW-1:0]]) : 64'(0));
            chk("m_we_o", 64'(m_we_o), have ? 64'(f_we[w[IW-1:0]]) : 64'(0));
            chk("m_be_o", 64'(m_be_o), have ? 64'(f_be[w[IW-1:0]]) : 64'(0));
            chk("m_wdata_o", 64'(m_wdata_o), have ? 64'(f_wdata[w[IW-1:0]]) : 64'(0));
        end

        @(posedge clk_i);
        if (rst_i) begin
            m_locked = 1'b0;
            m_ptr    = 0;
            q.delete();
            m_err    = 1'b0;
        end else begin
            if (m_rvalid_i && q.size() == 0) m_err = 1'b1;
            if (e_pop) void'(q.pop_front());
            if (hs) begin
                q.push_back(w);
                m_ptr    = (w + 1) % N;
                m_locked = 1'b0;
                req[w[IW-1:0]] = 1'b0;
            end else if (have) begin
                m_locked = 1'b1;
                m_lock   = w;
            end
        end
        #1;
    endtask

    task automatic set_fields(input int k);
        f_addr[k]  = $urandom;
        f_we[k]    = 1'($urandom_range(0, 1));
        f_be[k]    = 4'($urandom_range(0, 15));
        f_wdata[k] = $urandom;
    endtask

    initial begin
        req        = '0;
        m_gnt_i    = 1'b0;
        m_rvalid_i = 1'b0;
        m_rdata_i  = '0;
        for (int k = 0; k < N; k++) set_fields(k);
        m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_err = 1'b0;
        rst_i = 1'b1;
        drive();
        @(posedge clk_i);
        #1;
        cycle();
        rst_i = 1'b0;
        cycle();

        // Single requester granted in the same cycle.
        req = 2'b01; m_gnt_i = 1'b1;
        cycle();
        chk("t1_ptr_moves", 64'(m_ptr), 64'(1));

        // Both requesting: grants alternate; drain keeps occupancy low.
        m_rvalid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req = 2'b11;
            m_rdata_i = $urandom;
            cycle();
        end
        req = '0;
        cycle();
        m_rvalid_i = 1'b0;

        // Locked winner stays presented while the other requester rises.
        req = 2'b01; m_gnt_i = 1'b0;
        cycle();
        req[1] = 1'b1;
        cycle();
        cycle();
        chk("t3_locked_addr", 64'(m_addr_o), 64'(f_addr[0]));
        m_gnt_i = 1'b1;
        cycle();
        cycle();
        m_gnt_i = 1'b0; m_rvalid_i = 1'b1;
        cycle();
        cycle();
        m_rvalid_i = 1'b0;

        // Four outstanding grants fill the ID FIFO.
        m_gnt_i = 1'b1;
        for (int i = 0; i < MO; i++) begin
            req[0] = 1'b1;
            cycle();
        end
        req[0] = 1'b1;
        drive();
        #1;
        chk("t4_full_blocks", 64'(m_req_o), 64'(0));
        m_rvalid_i = 1'b1;
        cycle();
        m_rvalid_i = 1'b0;
        drive();
        #1;
        chk("t4_after_pop", 64'(m_req_o), 64'(1));
        cycle();
        m_gnt_i = 1'b0; m_rvalid_i = 1'b1;
        for (int i = 0; i < MO; i++) cycle();
        m_rvalid_i = 1'b0;

        // Grant order 0,1,0 then responses A,B,C.
        m_gnt_i = 1'b1;
        req = 2'b01; cycle();
        req = 2'b10; cycle();
        req = 2'b01; cycle();
        m_gnt_i = 1'b0; m_rvalid_i = 1'b1;
        m_rdata_i = 32'hAAAA_0001; cycle();
        m_rdata_i = 32'hBBBB_0002; cycle();
        m_rdata_i = 32'hCCCC_0003; cycle();

        // Spurious response sets the sticky error; reset mid-lock clears it.
        m_rdata_i = 32'hDEAD_BEEF;
        cycle();
        m_rvalid_i = 1'b0;
        cycle();
        chk("t6_err_sticky", 64'(err_o), 64'(1));
        req = 2'b01;
        cycle();
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        cycle();
        chk("t6_err_cleared", 64'(err_o), 64'(0));
        m_gnt_i = 1'b1;
        cycle();
        m_gnt_i = 1'b0;
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        m_rvalid_i = 1'b1;
        cycle();
        m_rvalid_i = 1'b0;
        cycle();
        chk("t6_late_rsp_err", 64'(err_o), 64'(1));
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;

        // Randomized traffic obeying the hold-until-granted rule.
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    set_fields(k);
                    req[k] = 1'b1;
                end
            end
            m_gnt_i    = 1'($urandom_range(0, 1));
            m_rvalid_i = (q.size() != 0) && ($urandom_range(0, 2) == 0);
            m_rdata_i  = $urandom;
            rst_i      = ($urandom_range(0, 149) == 0);
            cycle();
        end
        rst_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
